// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its result queue.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LQ
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of writeback requests with a combinational head entry.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  wb_req_t       data_i,
    input  logic          pop_i,
    output wb_req_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU results and queued load/mul-div results onto the single
// register-file write port, with a starvation guard for the queue head.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int LQ_DEPTH     = 4,
    parameter  int STARVE_LIMIT = 3,
    localparam int CW           = $clog2(LQ_DEPTH) + 1,
    localparam int AGW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            mem_valid_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            mem_ready_o,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_adrw_o,
    output logic [XLEN-1:0] rf_wd_o,
    output logic [CW-1:0]   lq_count_o
);

    wb_req_t          lq_head, win_req, mem_req;
    logic             lq_full, lq_empty, lq_pop, starve;
    wb_src_e          win_src;
    logic [AGW-1:0]   age_q, age_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_adrw_q, rf_adrw_d;
    logic [XLEN-1:0]  rf_wd_q, rf_wd_d;

    assign mem_req = '{rd: mem_rd_i, data: mem_data_i};

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (mem_valid_i),
        .data_i  (mem_req),
        .pop_i   (lq_pop),
        .head_o  (lq_head),
        .full_o  (lq_full),
        .empty_o (lq_empty),
        .count_o (lq_count_o)
    );

    assign starve      = (age_q == AGW'(STARVE_LIMIT)) && !lq_empty;
    assign alu_ready_o = !starve;
    assign mem_ready_o = !lq_full;

    always_comb begin
        win_src = SRC_NONE;
        win_req = lq_head;
        if (starve) begin
            win_src = SRC_LQ;
        end else if (alu_valid_i) begin
            win_src = SRC_ALU;
            win_req = '{rd: alu_rd_i, data: alu_data_i};
        end else if (!lq_empty) begin
            win_src = SRC_LQ;
        end
        lq_pop = (win_src == SRC_LQ);

        age_d = age_q;
        if (lq_empty || lq_pop)                  age_d = '0;
        else if (age_q != AGW'(STARVE_LIMIT))    age_d = age_q + 1'b1;

        // Address/data hold when idle; x0 results complete but never write.
        rf_we_d   = 1'b0;
        rf_adrw_d = rf_adrw_q;
        rf_wd_d   = rf_wd_q;
        if (win_src != SRC_NONE) begin
            rf_we_d   = (win_req.rd != '0);
            rf_adrw_d = win_req.rd;
            rf_wd_d   = win_req.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_adrw_q <= '0;
            rf_wd_q   <= '0;
        end else begin
            age_q     <= age_d;
            rf_we_q   <= rf_we_d;
            rf_adrw_q <= rf_adrw_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

    assign rf_we_o   = rf_we_q;
    assign rf_adrw_o = rf_adrw_q;
    assign rf_wd_o   = rf_wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a queue-based reference model checked every cycle.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            alu_ready;
    logic            mem_valid = 1'b0;
    logic [AW-1:0]   mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            mem_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_adrw;
    logic [XLEN-1:0] rf_wd;
    logic [2:0]      lq_count;

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid),
        .alu_rd_i    (alu_rd),
        .alu_data_i  (alu_data),
        .alu_ready_o (alu_ready),
        .mem_valid_i (mem_valid),
        .mem_rd_i    (mem_rd),
        .mem_data_i  (mem_data),
        .mem_ready_o (mem_ready),
        .rf_we_o     (rf_we),
        .rf_adrw_o   (rf_adrw),
        .rf_wd_o     (rf_wd),
        .lq_count_o  (lq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending results plus how many cycles the head has lost.
    wb_req_t         mq[$];
    int              m_lost = 0;
    bit              m_we = 0;
    logic [AW-1:0]   m_adrw = '0;
    logic [XLEN-1:0] m_wd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_lost = 0;
            m_we   = 0;
            m_adrw = '0;
            m_wd   = '0;
        end else begin
            int      sz;
            bit      have, popped;
            wb_req_t w;
            sz = mq.size();
            have = 0;
            popped = 0;
            w = '0;
            if (sz > 0 && m_lost == LIMIT) begin
                w = mq[0]; have = 1; popped = 1;
            end else if (alu_valid) begin
                w.rd = alu_rd; w.data = alu_data; have = 1;
            end else if (sz > 0) begin
                w = mq[0]; have = 1; popped = 1;
            end
            if (have) begin
                m_we = (w.rd != 0); m_adrw = w.rd; m_wd = w.data;
            end else begin
                m_we = 0;
            end
            if (sz == 0 || popped) m_lost = 0;
            else if (m_lost < LIMIT) m_lost = m_lost + 1;
            if (popped) void'(mq.pop_front());
            if (mem_valid && sz < DEPTH) begin
                wb_req_t p;
                p.rd = mem_rd; p.data = mem_data;
                mq.push_back(p);
            end
        end
    end

    always @(negedge clk) begin
        chk("rf_we", rf_we, m_we);
        chk("rf_adrw", rf_adrw, m_adrw);
        chk("rf_wd", rf_wd, m_wd);
        chk("lq_count", lq_count, mq.size());
        chk("mem_ready", mem_ready, mq.size() < DEPTH);
        chk("alu_ready", alu_ready, !(mq.size() > 0 && m_lost == LIMIT));
    end

    // Observation monitors used by the directed literal checks.
    int  we_seen = 0;
    int  stale_seen = 0;
    bit  stale_en = 0;
    int  log_rd[$];
    logic [XLEN-1:0] log_wd[$];

    always @(negedge clk) begin
        if (rf_we) we_seen++;
        if (stale_en && rf_we && rf_adrw >= 8 && rf_adrw <= 10) stale_seen++;
        if (rf_we && rf_adrw >= 1 && rf_adrw <= 5) begin
            log_rd.push_back(int'(rf_adrw));
            log_wd.push_back(rf_wd);
        end
    end

    initial begin
        int idx, full_cyc, forced;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_we", rf_we, 0);
        chk("rst_cnt", lq_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_we", rf_we, 0);
        chk("idle_adrw", rf_adrw, 0);
        chk("idle_wd", rf_wd, 0);
        chk("idle_mem_ready", mem_ready, 1);
        chk("idle_alu_ready", alu_ready, 1);

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        alu_valid = 0;
        chk("alu_we", rf_we, 1);
        chk("alu_adrw", rf_adrw, 5);
        chk("alu_wd", rf_wd, 32'hDEADBEEF);
        @(negedge clk);
        chk("alu_we_drop", rf_we, 0);

        // x0 suppression from both sources
        we_seen = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        @(negedge clk);
        alu_valid = 0;
        mem_valid = 1; mem_rd = 0; mem_data = 32'h5678;
        @(negedge clk);
        mem_valid = 0;
        chk("x0_push_cnt", lq_count, 1);
        repeat (4) @(negedge clk);
        chk("x0_we_seen", we_seen, 0);
        chk("x0_cnt", lq_count, 0);

        // Queue fill, backpressure and starvation retirement
        idx = 0; full_cyc = -1; forced = 0;
        log_rd.delete(); log_wd.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!alu_ready) forced++;
            if (full_cyc >= 0 && cyc == full_cyc + 1) begin
                chk("full_pop_cnt", lq_count, 3);
                chk("full_pop_ready", mem_ready, 1);
            end
            if (lq_count == 4 && full_cyc < 0) begin
                full_cyc = cyc;
                chk("full_mem_ready", mem_ready, 0);
                chk("full_alu_ready", alu_ready, 0);
                chk("full_mem_valid", mem_valid, 1);
            end
            alu_valid = 1; alu_rd = 20; alu_data = XLEN'(cyc);
            mem_valid = (idx < 5);
            mem_rd    = AW'(idx + 1);
            mem_data  = XLEN'((idx + 1) * 16);
            if (mem_valid && mem_ready) idx++;
        end
        alu_valid = 0; mem_valid = 0;
        chk("fill_reached_full", full_cyc >= 0, 1);
        chk("fill_forced", forced, 5);
        chk("fill_retired", log_rd.size(), 5);
        for (int i = 0; i < 5 && i < log_rd.size(); i++) begin
            chk("fill_order_rd", log_rd[i], i + 1);
            chk("fill_order_wd", log_wd[i], (i + 1) * 16);
        end
        repeat (2) @(negedge clk);
        chk("fill_drain", lq_count, 0);

        // Async reset mid-flight
        alu_valid = 1; alu_rd = 7; alu_data = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = AW'(8 + i); mem_data = XLEN'(32'h800 + i);
            @(negedge clk);
        end
        mem_valid = 0;
        chk("pre_rst_cnt", lq_count, 3);
        chk("pre_rst_we", rf_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_cnt", lq_count, 0);
        alu_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale_en = 1;
        repeat (10) @(negedge clk);
        chk("no_stale_write", stale_seen, 0);
        chk("post_rst_cnt", lq_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
